// File: rtl/tetris_draw_pkg.sv
// Shared definitions for the Tetris board drawing path (board scanner and
// cell pixel writer): board and screen geometry, coordinate widths, the
// grid-line colour and the cell-writer FSM state type.
package tetris_draw_pkg;

    // Board geometry in cells
    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;

    // Screen geometry in pixels
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Coordinate widths
    localparam int CELL_COORD_W = 5;
    localparam int PIX_X_W      = 10;
    localparam int PIX_Y_W      = 9;

    // Grid-line colour; consumers truncate it to their own colour width
    localparam logic [7:0] BORDER_COLOR = 8'h07;

    // Cell writer FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } draw_state_e;

endpackage

// File: rtl/cell_pixel_writer_if.sv
// Bundle between the board scanner (master), the cell pixel writer (slave)
// and the framebuffer write port. The scanner side drives the cell request;
// the writer drives the handshake status and the pixel write strobe.
interface cell_pixel_writer_if #(
    parameter int COLOR_W = 3
) ();
    import tetris_draw_pkg::*;

    logic                      start;
    logic [CELL_COORD_W-1:0]   cell_x;
    logic [CELL_COORD_W-1:0]   cell_y;
    logic [COLOR_W-1:0]        cell_color;
    logic                      ready;
    logic [PIX_X_W-1:0]        pixel_x;
    logic [PIX_Y_W-1:0]        pixel_y;
    logic [COLOR_W-1:0]        pixel_color;
    logic                      pixel_we;
    logic                      done;

    modport master (
        output start, cell_x, cell_y, cell_color,
        input  ready, pixel_x, pixel_y, pixel_color, pixel_we, done
    );

    modport slave (
        input  start, cell_x, cell_y, cell_color,
        output ready, pixel_x, pixel_y, pixel_color, pixel_we, done
    );

endinterface

// File: rtl/cell_pixel_counter.sv
// Raster position inside one cell: dx runs fastest, dy advances when dx
// wraps. last flags the bottom-right pixel of the square.
module cell_pixel_counter #(
    parameter  int CELL_PX = 8,
    localparam int SHIFT   = $clog2(CELL_PX)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [SHIFT-1:0] o_dx,
    output logic [SHIFT-1:0] o_dy,
    output logic             o_last
);

    localparam logic [SHIFT-1:0] MAX = SHIFT'(CELL_PX - 1);

    logic [SHIFT-1:0] r_dx;
    logic [SHIFT-1:0] r_dy;

    // Raster counters: clear to the top-left pixel, otherwise step in raster order
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values of its neighbours.
        if (reset || i_clear) begin
            r_dx <= '0;
            r_dy <= '0;
        end else if (i_inc) begin
            r_dx <= r_dx + SHIFT'(1);
            if (r_dx == MAX) begin
                r_dy <= r_dy + SHIFT'(1);
            end
        end
    end

    assign o_dx   = r_dx;
    assign o_dy   = r_dy;
    assign o_last = (r_dx == MAX) && (r_dy == MAX);

endmodule

// File: rtl/cell_pixel_writer.sv
// Rasterises one board cell into a CELL_PX x CELL_PX square of framebuffer
// writes, one pixel per cycle. The output registers are loaded from the
// pixel the FSM is about to present, so the first write appears on the
// cycle right after the request is accepted.
// Optional feature: define CELL_BORDER_EN to paint the top row and left
// column of every cell with BORDER_COLOR (one-pixel grid lines).
module cell_pixel_writer
    import tetris_draw_pkg::*;
#(
    parameter int CELL_PX  = 8,
    parameter int ORIGIN_X = 200,
    parameter int ORIGIN_Y = 80,
    parameter int COLOR_W  = 3
) (
    input logic                clk,
    input logic                reset,
    cell_pixel_writer_if.slave cp
);

    localparam int SHIFT = $clog2(CELL_PX);

    // Elaboration-time parameter checks
    if (CELL_PX < 2 || CELL_PX > 32 || (CELL_PX & (CELL_PX - 1)) != 0) begin : g_bad_cell_px
        $error("cell_pixel_writer: CELL_PX must be a power of two in 2..32");
    end
    if (ORIGIN_X + BOARD_W * CELL_PX > SCREEN_W) begin : g_bad_origin_x
        $error("cell_pixel_writer: board exceeds screen width");
    end
    if (ORIGIN_Y + BOARD_H * CELL_PX > SCREEN_H) begin : g_bad_origin_y
        $error("cell_pixel_writer: board exceeds screen height");
    end

    draw_state_e               r_state;
    draw_state_e               w_state_next;

    logic [CELL_COORD_W-1:0]   r_cell_x;
    logic [CELL_COORD_W-1:0]   r_cell_y;
    logic [COLOR_W-1:0]        r_cell_color;

    logic [PIX_X_W-1:0]        r_pixel_x;
    logic [PIX_Y_W-1:0]        r_pixel_y;
    logic [COLOR_W-1:0]        r_pixel_color;
    logic                      r_pixel_we;
    logic                      r_done;

    logic                      w_accept;
    logic                      w_cnt_inc;
    logic                      w_in_range;
    logic                      w_last;
    logic                      w_wrap;
    logic [SHIFT-1:0]          w_dx;
    logic [SHIFT-1:0]          w_dy;
    logic [SHIFT-1:0]          w_off_x;
    logic [SHIFT-1:0]          w_off_y;
    logic [CELL_COORD_W-1:0]   w_src_x;
    logic [CELL_COORD_W-1:0]   w_src_y;
    logic [COLOR_W-1:0]        w_src_color;
    logic [COLOR_W-1:0]        w_fill_color;
    logic [PIX_X_W-1:0]        w_base_x;
    logic [PIX_Y_W-1:0]        w_base_y;

    cell_pixel_counter #(
        .CELL_PX (CELL_PX)
    ) u_counter (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_accept),
        .i_inc   (w_cnt_inc),
        .o_dx    (w_dx),
        .o_dy    (w_dy),
        .o_last  (w_last)
    );

    assign w_in_range = (cp.cell_x <= CELL_COORD_W'(BOARD_W - 1)) &&
                        (cp.cell_y <= CELL_COORD_W'(BOARD_H - 1));

    // Next-state decode and counter control
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would infer a latch.
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_cnt_inc    = 1'b0;
        case (r_state)
            IDLE: begin
                if (cp.start) begin
                    w_accept     = 1'b1;
                    w_state_next = w_in_range ? DRAW : DONE;
                end
            end
            DRAW: begin
                if (w_last) begin
                    w_state_next = DONE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // On the accepting edge the latches are not loaded yet, so the first
    // pixel is taken straight from the request inputs.
    assign w_src_x     = (r_state == IDLE) ? cp.cell_x     : r_cell_x;
    assign w_src_y     = (r_state == IDLE) ? cp.cell_y     : r_cell_y;
    assign w_src_color = (r_state == IDLE) ? cp.cell_color : r_cell_color;

    assign w_base_x = PIX_X_W'(ORIGIN_X) + (PIX_X_W'(w_src_x) << SHIFT);
    assign w_base_y = PIX_Y_W'(ORIGIN_Y) + (PIX_Y_W'(w_src_y) << SHIFT);

    // Offset of the pixel being loaded into the output registers: the top-left
    // pixel on acceptance, otherwise the raster successor of the current one.
    assign w_wrap  = (w_dx == SHIFT'(CELL_PX - 1));
    assign w_off_x = w_accept ? '0 : w_dx + SHIFT'(1);
    assign w_off_y = w_accept ? '0 : w_dy + SHIFT'(w_wrap);

`ifdef CELL_BORDER_EN
    assign w_fill_color = (w_off_x == '0 || w_off_y == '0) ? COLOR_W'(BORDER_COLOR)
                                                           : w_src_color;
`else
    assign w_fill_color = w_src_color;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request latches, loaded only when a request is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cell_x     <= '0;
            r_cell_y     <= '0;
            r_cell_color <= '0;
        end else if (w_accept) begin
            r_cell_x     <= cp.cell_x;
            r_cell_y     <= cp.cell_y;
            r_cell_color <= cp.cell_color;
        end
    end

    // Output registers track the state being entered, so strobes line up with it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_pixel_color <= '0;
            r_pixel_we    <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_pixel_we <= (w_state_next == DRAW);
            r_done     <= (w_state_next == DONE);
            if (w_state_next == DRAW) begin
                r_pixel_x     <= w_base_x + PIX_X_W'(w_off_x);
                r_pixel_y     <= w_base_y + PIX_Y_W'(w_off_y);
                r_pixel_color <= w_fill_color;
            end
        end
    end

    assign cp.ready       = (r_state == IDLE);
    assign cp.pixel_x     = r_pixel_x;
    assign cp.pixel_y     = r_pixel_y;
    assign cp.pixel_color = r_pixel_color;
    assign cp.pixel_we    = r_pixel_we;
    assign cp.done        = r_done;

endmodule

// File: tb/tb_cell_pixel_writer.sv
// Scoreboard bench for cell_pixel_writer at default parameters. The driver
// pushes every expected write/done (with the edge count at which it must be
// visible) into a queue; a negedge monitor pops and compares whenever the
// DUT strobes pixel_we or done, and checks ready against the busy window.
// Observation convention: the value seen at the negedge following edge n
// is the value presented in cycle n+1 relative to an accept at edge n-k.
module tb_cell_pixel_writer;
    import tetris_draw_pkg::*;

    localparam int CPX = 8;
    localparam int OX  = 200;
    localparam int OY  = 80;
    localparam int CW  = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    cell_pixel_writer_if #(.COLOR_W(CW)) bus ();

    cell_pixel_writer #(
        .CELL_PX  (CPX),
        .ORIGIN_X (OX),
        .ORIGIN_Y (OY),
        .COLOR_W  (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cp    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int x;
        int y;
        int c;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cnt      = 0;
    int   n_checks = 0;
    int   n_err    = 0;
    int   busy_lo  = 1;
    int   busy_hi  = 0;
    bit   chk_en   = 1'b0;

    always @(posedge clk) cnt <= cnt + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, cnt, got, exp);
        end
    endtask

    function automatic int exp_color(int dx, int dy, int col);
`ifdef CELL_BORDER_EN
        if (dx == 0 || dy == 0) return int'(BORDER_COLOR) & ((1 << CW) - 1);
`endif
        return col + 0 * (dx + dy);
    endfunction

    // Reference model: a request accepted at edge a yields pixel k visible
    // at edge a+k, done at a+CPX*CPX, ready again one edge later. An
    // out-of-range cell yields only done at edge a. abort_k >= 0 means a
    // reset cuts the square after abort_k pixels, with no done.
    task automatic expect_req(int cx, int cy, int col, int a, int abort_k);
        exp_t e;
        if (cx <= BOARD_W - 1 && cy <= BOARD_H - 1) begin
            for (int dy = 0; dy < CPX; dy++) begin
                for (int dx = 0; dx < CPX; dx++) begin
                    int k = dy * CPX + dx;
                    if (abort_k < 0 || k < abort_k) begin
                        e.is_done = 1'b0;
                        e.x   = OX + cx * CPX + dx;
                        e.y   = OY + cy * CPX + dy;
                        e.c   = exp_color(dx, dy, col);
                        e.cyc = a + k;
                        sb.push_back(e);
                    end
                end
            end
            busy_lo = a;
            if (abort_k < 0) begin
                e = '{1'b1, 0, 0, 0, a + CPX * CPX};
                sb.push_back(e);
                busy_hi = a + CPX * CPX;
            end else begin
                busy_hi = a + abort_k - 1;
            end
        end else begin
            e = '{1'b1, 0, 0, 0, a};
            sb.push_back(e);
            busy_lo = a;
            busy_hi = a;
        end
    endtask

    // Monitor: ready window every cycle, outputs popped from the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            check("ready", bus.ready, (cnt >= busy_lo && cnt <= busy_hi) ? 0 : 1);
            if (bus.pixel_we === 1'b1 || bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", {bus.pixel_we, bus.done}, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_done", bus.done, e.is_done);
                    check("out_we", bus.pixel_we, !e.is_done);
                    check("out_cycle", cnt, e.cyc);
                    if (!e.is_done) begin
                        check("pixel_x", bus.pixel_x, e.x);
                        check("pixel_y", bus.pixel_y, e.y);
                        check("pixel_color", bus.pixel_color, e.c);
                    end
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cnt) begin
                e = sb.pop_front();
                check("missing_output", {bus.pixel_we, bus.done}, e.is_done ? 1 : 2);
            end
        end
    end

    // Issue one request at a negedge once ready is seen; returns accept edge
    task automatic issue(int cx, int cy, int col, int abort_k, output int a);
        int g = 0;
        while (bus.ready !== 1'b1 && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) check("ready_timeout", bus.ready, 1);
        bus.start      = 1'b1;
        bus.cell_x     = cx[4:0];
        bus.cell_y     = cy[4:0];
        bus.cell_color = col[CW-1:0];
        a = cnt + 1;
        expect_req(cx, cy, col, a, abort_k);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((sb.size() != 0 || cnt <= busy_hi) && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 1000) check("idle_timeout", sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int a;
        int bx[4] = '{1, 10, 8, 0};
        int by[4] = '{2, 5, 17, 19};
        int bc[4] = '{3, 6, 1, 7};

        bus.start      = 1'b0;
        bus.cell_x     = '0;
        bus.cell_y     = '0;
        bus.cell_color = '0;

        // Reset for two cycles, then check reset values and idle behaviour
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        check("rst_ready", bus.ready, 1);
        check("rst_pixel_we", bus.pixel_we, 0);
        check("rst_done", bus.done, 0);
        check("rst_pixel_x", bus.pixel_x, 0);
        check("rst_pixel_y", bus.pixel_y, 0);
        check("rst_pixel_color", bus.pixel_color, 0);
        repeat (5) @(negedge clk);

        // Corner cells
        issue(0, 0, 5, -1, a);
        wait_idle();
        issue(9, 19, 2, -1, a);
        wait_idle();

        // A start while busy is ignored
        issue(3, 3, 4, -1, a);
        while (cnt < a + 9) @(negedge clk);
        bus.start  = 1'b1;
        bus.cell_x = 5'd4;
        bus.cell_y = 5'd4;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // Out-of-range cells: no writes, immediate done
        issue(10, 0, 1, -1, a);
        wait_idle();
        issue(0, 20, 1, -1, a);
        wait_idle();
        issue(31, 31, 6, -1, a);
        wait_idle();

        // Reset in cycle 20 of a draw abandons the square, then a full redraw
        issue(3, 5, 6, 20, a);
        while (cnt < a + 19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        issue(3, 5, 6, -1, a);
        wait_idle();

        // start held high: each request accepted on the first IDLE cycle
        bus.start = 1'b1;
        for (int r = 0; r < 4; r++) begin
            int g = 0;
            bus.cell_x     = bx[r][4:0];
            bus.cell_y     = by[r][4:0];
            bus.cell_color = bc[r][CW-1:0];
            while (bus.ready !== 1'b1 && g < 500) begin
                @(negedge clk);
                g++;
            end
            if (g >= 500) check("b2b_ready_timeout", bus.ready, 1);
            a = cnt + 1;
            expect_req(bx[r], by[r], bc[r], a, -1);
            @(negedge clk);
        end
        bus.start = 1'b0;
        wait_idle();

        // Random requests including out-of-range coordinates
        for (int r = 0; r < 20; r++) begin
            int cx  = $urandom_range(0, 11);
            int cy  = $urandom_range(0, 21);
            int col = $urandom_range(0, 7);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(cx, cy, col, -1, a);
        end
        wait_idle();

        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
